seqgen: RTL and testbench

Serial pattern transmitter: the source end of the single-bit serial stream consumed by the team's `101` sequence detector.
- Captures a parallel pattern word, a bit length and a repeat count on a start request, then shifts the pattern out MSB-first, one bit per clock, on `x`.
- Keeps a reference count of overlapping `101` occurrences in the bits it transmits, so benches can compare it directly against the detector's `z` pulses.

---
 rtl/seqgen_if.sv | 30 +++
 rtl/seqgen.sv | 128 ++++++++++++
 tb/tb_seqgen.sv | 112 +++++++++++
 3 files changed

// File: rtl/seqgen_if.sv
// Request/stream bundle between a pattern source (master) and the seqgen transmitter (slave).
// The master drives the request fields; the slave returns the serial stream and status.
interface seqgen_if #(
  parameter int W  = 16,
  parameter int LW = 5,
  parameter int CW = 8
) ();

  logic          start;
  logic [W-1:0]  data;
  logic [LW-1:0] len;
  logic [CW-1:0] rpt;

  logic          x;
  logic          valid;
  logic          busy;
  logic          done;
  logic [CW-1:0] hits;

  modport master (
    output start, data, len, rpt,
    input  x, valid, busy, done, hits
  );

  modport slave (
    input  start, data, len, rpt,
    output x, valid, busy, done, hits
  );

endinterface

// File: rtl/seqgen.sv
// Serial pattern transmitter: shifts data[len-1:0] out MSB-first, rpt+1 times back to back,
// and keeps a saturating count of overlapping 101 occurrences in the transmitted bits.
module seqgen #(
  parameter int W  = 16,
  parameter int LW = 5,
  parameter int CW = 8
) (
  input  logic    clk,
  input  logic    reset,
  seqgen_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [LW-1:0] LEN_MAX  = LW'(W);
  localparam logic [CW-1:0] HITS_MAX = '1;

  state_t        r_state;
  logic [W-1:0]  r_pattern;
  logic [W-1:0]  r_shift;
  logic [LW-1:0] r_len;
  logic [LW-1:0] r_bitcnt;
  logic [CW-1:0] r_pass;
  logic [1:0]    r_hist;
  logic [CW-1:0] r_hits;
  logic          r_x;
  logic          r_valid;
  logic          r_busy;
  logic          r_done;

  logic [LW-1:0] w_len;
  logic [W-1:0]  w_aligned;
  logic          w_hit;

  // Left-align the field so its MSB always sits at the top of the shift register.
  assign w_len     = (bus.len > LEN_MAX) ? LEN_MAX : bus.len;
  assign w_aligned = bus.data << (LEN_MAX - w_len);
  assign w_hit     = (r_hist == 2'b10) && r_x;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_pattern <= '0;
      r_shift   <= '0;
      r_len     <= '0;
      r_bitcnt  <= '0;
      r_pass    <= '0;
      r_hist    <= '0;
      r_hits    <= '0;
      r_x       <= 1'b0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_hits    <= '0;
            r_hist    <= '0;
            r_pattern <= w_aligned;
            r_len     <= w_len;
            r_pass    <= bus.rpt;
            r_busy    <= 1'b1;
            if (w_len == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state  <= S_SEND;
              r_valid  <= 1'b1;
              r_x      <= w_aligned[W-1];
              r_shift  <= {w_aligned[W-2:0], 1'b0};
              r_bitcnt <= w_len - 1'b1;
            end
          end
        end

        S_SEND: begin
          // The bit currently on x is scored here, so hits lags the bit by one cycle.
          r_hist <= {r_hist[0], r_x};
          if (w_hit && (r_hits != HITS_MAX)) begin
            r_hits <= r_hits + 1'b1;
          end
          if (r_bitcnt != '0) begin
            r_x      <= r_shift[W-1];
            r_shift  <= {r_shift[W-2:0], 1'b0};
            r_bitcnt <= r_bitcnt - 1'b1;
          end else if (r_pass != '0) begin
            r_pass   <= r_pass - 1'b1;
            r_x      <= r_pattern[W-1];
            r_shift  <= {r_pattern[W-2:0], 1'b0};
            r_bitcnt <= r_len - 1'b1;
          end else begin
            r_state <= S_DONE;
            r_x     <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b1;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_x     <= 1'b0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.x     = r_x;
  assign bus.valid = r_valid;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.hits  = r_hits;

endmodule

// File: tb/tb_seqgen.sv
// Directed bench for seqgen: hand-computed streams, transfer lengths and 101 hit counts.
module tb_seqgen;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_err = 0;
  int   n_chk = 0;

  always #5 clk = ~clk;

  seqgen_if #(.W(16), .LW(5), .CW(8)) bus ();

  seqgen #(.W(16), .LW(5), .CW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transfer; glitch >= 0 pulses start (with len=0) at that observed cycle.
  task automatic run(input string tag, input logic [15:0] d, input logic [4:0] l,
                     input logic [7:0] r, input int glitch, input int exp_bits,
                     input logic [31:0] exp_tail, input logic [7:0] exp_hits);
    int          nbits  = 0;
    int          nbusy  = 0;
    int          done_c = -1;
    int          xbad   = 0;
    logic [31:0] tail   = '0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.data  = d;
    bus.len   = l;
    bus.rpt   = r;
    @(negedge clk);
    bus.start = 1'b0;
    bus.data  = 16'hFFFF;
    bus.len   = 5'd7;
    bus.rpt   = 8'd3;
    for (int c = 0; c < 2000 && done_c < 0; c++) begin
      if (c > 0) @(negedge clk);
      bus.start = (c == glitch);
      if (c == glitch) bus.len = 5'd0;
      if (bus.valid) begin
        nbits++;
        tail = {tail[30:0], bus.x};
      end else if (bus.x) begin
        xbad++;
      end
      if (bus.busy) nbusy++;
      if (bus.done) done_c = c;
    end
    bus.start = 1'b0;
    check({tag, "/done_at"}, done_c, exp_bits);
    check({tag, "/nbits"}, nbits, exp_bits);
    check({tag, "/stream"}, tail, exp_tail);
    check({tag, "/busy_cyc"}, nbusy, exp_bits + 1);
    check({tag, "/x_idle"}, xbad, 0);
    check({tag, "/hits"}, {24'd0, bus.hits}, {24'd0, exp_hits});
    @(negedge clk);
    check({tag, "/idle"}, {bus.busy, bus.done, bus.valid}, 3'b000);
    check({tag, "/hits_hold"}, {24'd0, bus.hits}, {24'd0, exp_hits});
    $display("xfer %s: bits=%0d tail=%0h hits=%0d", tag, nbits, tail, bus.hits);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.data  = '0;
    bus.len   = '0;
    bus.rpt   = '0;
    #1;
    check("reset_state", {bus.x, bus.valid, bus.busy, bus.done, bus.hits}, '0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    run("p101",    16'h0005, 5'd3,  8'd0,  -1, 3,   32'h0000_0005, 8'd1);
    run("p10101",  16'h0015, 5'd5,  8'd0,  -1, 5,   32'h0000_0015, 8'd2);
    run("rpt2",    16'h0005, 5'd3,  8'd2,  -1, 9,   32'h0000_016D, 8'd3);
    run("len0",    16'h0005, 5'd0,  8'd4,  -1, 0,   32'h0000_0000, 8'd0);
    run("clamp",   16'hC3A5, 5'd20, 8'd0,  -1, 16,  32'h0000_C3A5, 8'd2);
    run("glitch",  16'h0005, 5'd3,  8'd2,  2,  9,   32'h0000_016D, 8'd3);
    run("sat",     16'hAAAA, 5'd16, 8'd40, -1, 656, 32'hAAAA_AAAA, 8'd255);

    // Asynchronous reset in the middle of a transfer.
    @(negedge clk);
    bus.start = 1'b1;
    bus.data  = 16'h0015;
    bus.len   = 5'd5;
    bus.rpt   = 8'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_reset", {bus.valid, bus.busy, bus.hits}, {2'b11, 8'd2});
    #2 reset = 1'b0;
    #1;
    check("async_reset", {bus.x, bus.valid, bus.busy, bus.done, bus.hits}, '0);
    @(negedge clk);
    check("in_reset", {bus.x, bus.valid, bus.busy, bus.done, bus.hits}, '0);
    reset = 1'b1;
    run("after_rst", 16'h0005, 5'd3, 8'd0, -1, 3, 32'h0000_0005, 8'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
